// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter and the peripherals it addresses.
package periph_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ADDR,
        ST_RD_CAP,
        ST_DONE
    } state_e;

    // Parked address: no peripheral may decode it.
    localparam logic [7:0] PARK_ADDR_DEF = 8'hFF;
    localparam int         READ_LAT_DEF  = 1;

    localparam logic [7:0] LED_LSB = 8'hC0;
    localparam logic [7:0] LED_MSB = 8'hC1;

    // Down-counter load for the address phase; read latency is clamped to 1..7.
    function automatic logic [2:0] lat_load(input int lat);
        if (lat <= 1) return 3'd0;
        if (lat >= 7) return 3'd6;
        return 3'(lat - 1);
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// Request/grant handshake of both masters plus the registered bus-control outputs.
interface periph_bus_arbiter_if;

    logic       REQ0;
    logic       REQ1;
    logic [7:0] ADDR0;
    logic [7:0] ADDR1;
    logic       WE0;
    logic       WE1;
    logic [7:0] WDATA0;
    logic [7:0] WDATA1;
    logic       GNT0;
    logic       GNT1;
    logic       ACK0;
    logic       ACK1;
    logic [7:0] RDATA;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;

    modport master (
        output REQ0, REQ1, ADDR0, ADDR1, WE0, WE1, WDATA0, WDATA1,
        input  GNT0, GNT1, ACK0, ACK1, RDATA, BUS_ADDR, BUS_WE
    );

    modport slave (
        input  REQ0, REQ1, ADDR0, ADDR1, WE0, WE1, WDATA0, WDATA1,
        output GNT0, GNT1, ACK0, ACK1, RDATA, BUS_ADDR, BUS_WE
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick; on a tie the master not served last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win,
    output logic vld
);

    always_comb begin
        vld = req0 | req1;
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = 1'b1;
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter and single-transaction sequencer for the 8-bit peripheral bus.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter logic [7:0] PARK_ADDR = PARK_ADDR_DEF,
    parameter int         READ_LAT  = READ_LAT_DEF
) (
    input  logic                CLK,
    input  logic                RESET_N,
    periph_bus_arbiter_if.slave bus,
    inout  wire  [7:0]          BUS_DATA
);

    localparam logic [2:0] LAT_LOAD = lat_load(READ_LAT);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [7:0] bus_addr_q, bus_addr_d;
    logic       bus_we_q, bus_we_d;
    logic       bus_oe_q, bus_oe_d;
    logic       pick_win;
    logic       pick_vld;
    logic       pick_we;

    rr_pick2 u_pick (
        .req0 (bus.REQ0),
        .req1 (bus.REQ1),
        .last (last_q),
        .win  (pick_win),
        .vld  (pick_vld)
    );

    assign pick_we = pick_win ? bus.WE1 : bus.WE0;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_win;
                    last_d  = pick_win;
                    addr_d  = pick_win ? bus.ADDR1 : bus.ADDR0;
                    wdata_d = pick_win ? bus.WDATA1 : bus.WDATA0;
                    cnt_d   = LAT_LOAD;
                    state_d = pick_we ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: state_d = ST_DONE;
            ST_RD_ADDR: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_RD_CAP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RD_CAP: begin
                rdata_d = BUS_DATA;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        bus_addr_d = PARK_ADDR;
        bus_we_d   = 1'b0;
        bus_oe_d   = 1'b0;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        if (state_d == ST_WR || state_d == ST_RD_ADDR || state_d == ST_RD_CAP) begin
            bus_addr_d = addr_d;
        end
        if (state_d == ST_WR) begin
            bus_we_d = 1'b1;
            bus_oe_d = 1'b1;
        end
        if (state_d != ST_IDLE) begin
            gnt0_d = ~owner_d;
            gnt1_d = owner_d;
        end
        if (state_d == ST_DONE) begin
            ack0_d = ~owner_d;
            ack1_d = owner_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            cnt_q      <= 3'd0;
            rdata_q    <= 8'h00;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            bus_addr_q <= PARK_ADDR;
            bus_we_q   <= 1'b0;
            bus_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            bus_addr_q <= bus_addr_d;
            bus_we_q   <= bus_we_d;
            bus_oe_q   <= bus_oe_d;
        end
    end

    // Latched transaction payload; only consumed while the FSM owns it, so no reset needed.
    always_ff @(posedge CLK) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign BUS_DATA     = bus_oe_q ? wdata_q : 8'hzz;
    assign bus.GNT0     = gnt0_q;
    assign bus.GNT1     = gnt1_q;
    assign bus.ACK0     = ack0_q;
    assign bus.ACK1     = ack1_q;
    assign bus.RDATA    = rdata_q;
    assign bus.BUS_ADDR = bus_addr_q;
    assign bus.BUS_WE   = bus_we_q;

endmodule
